expu_sched: RTL and testbench
=============================

EXPU_SCHED -- requirements
Module: expu_sched

Interface
REQ-001 Parameter N_ROWS, default 1: number of EXPU lanes per beat.
REQ-002 Parameter CNT_WIDTH, default 16: width of the element-count fields.
REQ-003 clk_i  in  1: single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1: reset, asynchronous and active-low.
REQ-005 clear_i  in  1: synchronous soft clear.
REQ-006 start_i  in  1: job start pulse.
REQ-007 len_i  in  CNT_WIDTH: total number of elements in the job; sampled on an accepted start.
REQ-008 in_valid_i / in_ready_o  in/out  1/1: input operand-stream handshake.
REQ-009 expu_valid_o / expu_ready_i  out/in  1/1: issue handshake toward the EXPU; expu_ready_i is the EXPU ready output.
REQ-010 expu_strb_o  out  N_ROWS: lane strobe for the issued beat.
REQ-011 expu_tag_o  out  1: last-beat tag for the issued beat.
REQ-012 expu_enable_o / expu_clear_o  out  1/1: EXPU enable and clear.
REQ-013 expu_valid_i / expu_strb_i / expu_tag_i  in  1/N_ROWS/1: EXPU result side.
REQ-014 expu_out_ready_o  out  1: ready presented to the EXPU result side.
REQ-015 out_valid_o / out_ready_i  out/in  1/1: result-stream handshake.
REQ-016 out_strb_o / out_last_o  out  N_ROWS/1: result lane strobe and last flag.
REQ-017 busy_o / done_o  out  1/1: job in progress; one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, ISSUE, DRAIN and DONE.
REQ-019 IDLE->ISSUE on start_i with len_i!=0; len_i is loaded into the issue-remaining counter (rem) and the result-remaining counter (pend).
REQ-020 IDLE->DONE on start_i with len_i==0; no beat is issued.
REQ-021 start_i in any state other than IDLE SHALL be ignored.
REQ-022 In ISSUE: expu_valid_o=in_valid_i; in_ready_o=expu_ready_i; all combinational, zero added latency.
REQ-023 Outside ISSUE: expu_valid_o=0 and in_ready_o=0.
REQ-024 Issue beat fires when expu_valid_o & expu_ready_i.
REQ-025 Beat lanes: k=min(rem,N_ROWS); expu_strb_o = lowest k bits set.
REQ-026 expu_tag_o=1 iff rem<=N_ROWS.
REQ-027 On each issue fire, rem decrements by k (saturating at 0).
REQ-028 A fire with expu_tag_o=1 moves ISSUE->DRAIN.
REQ-029 Results: out_valid_o=expu_valid_i; expu_out_ready_o=out_ready_i; out_strb_o=expu_strb_i; all pass-through.
REQ-030 Results are counted in every non-IDLE state.
REQ-031 On each result fire (out_valid_o & out_ready_i), pend decrements by popcount(expu_strb_i).
REQ-032 out_last_o=1 iff out_valid_o and pend<=popcount(expu_strb_i).
REQ-033 DRAIN->DONE when the result fire with out_last_o=1 occurs.
REQ-034 DONE lasts exactly one cycle: done_o=1, then IDLE.
REQ-035 busy_o=1 in ISSUE and DRAIN.
REQ-036 expu_enable_o=1 in ISSUE and DRAIN, 0 otherwise.
REQ-037 expu_clear_o=clear_i, or 1 for the one cycle of IDLE->ISSUE, so the EXPU pipeline starts each job empty.
REQ-038 Simultaneous issue fire and result fire in one cycle SHALL update rem and pend independently.
REQ-039 clear_i SHALL force IDLE, zero rem and pend, and suppress done_o; clear_i has priority over start_i.

Reset
REQ-040 While rst_ni=0, state SHALL be IDLE and rem=pend=0.
REQ-041 While rst_ni=0, all outputs SHALL be 0: busy_o, done_o, in_ready_o, expu_valid_o, expu_enable_o, out_valid_o, out_last_o, expu_clear_o.
REQ-042 Reset asserted mid-job SHALL abort the job with no done_o pulse.

Verification
REQ-043 N_ROWS=4, len_i=10, always ready -> 3 issue beats with strb 1111,1111,0011; tag only on the third; 10 results; out_last_o on the final beat; done_o one cycle after it.
REQ-044 len_i=0 -> done_o high the cycle after start_i; no expu_valid_o.
REQ-045 out_ready_i low for 5 cycles during DRAIN -> no result beats lost; done_o only after the last result is accepted; busy_o held.
REQ-046 start_i pulsed during ISSUE -> ignored; rem unchanged.
REQ-047 clear_i during DRAIN -> IDLE next cycle; expu_clear_o=1 that cycle; no done_o; a new start then completes normally.
REQ-048 rst_ni low mid-ISSUE -> all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/expu_sched.sv
// Job scheduler for an N_ROWS-lane EXPU: slices a job into lane-strobed issue beats and counts results back in.
// Zero-latency combinational handshakes in both directions; backpressure passes straight through from EXPU/sink.
module expu_sched #(
   parameter int N_ROWS    = 1,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  logic [CNT_WIDTH-1:0] len_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic                 expu_valid_o,
   input  logic                 expu_ready_i,
   output logic [N_ROWS-1:0]    expu_strb_o,
   output logic                 expu_tag_o,
   output logic                 expu_enable_o,
   output logic                 expu_clear_o,
   input  logic                 expu_valid_i,
   input  logic [N_ROWS-1:0]    expu_strb_i,
   input  logic                 expu_tag_i,
   output logic                 expu_out_ready_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [N_ROWS-1:0]    out_strb_o,
   output logic                 out_last_o,
   output logic                 busy_o,
   output logic                 done_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [CNT_WIDTH-1:0] ROWS = CNT_WIDTH'(N_ROWS);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] rem_q, rem_d;
   logic [CNT_WIDTH-1:0] pend_q, pend_d;
   logic [CNT_WIDTH-1:0] beat_k;
   logic [CNT_WIDTH-1:0] res_cnt;
   logic                 issue_fire;
   logic                 res_fire;
   logic                 unused_tag;

   function automatic logic [CNT_WIDTH-1:0] popcnt(input logic [N_ROWS-1:0] v);
      popcnt = '0;
      for (int i = 0; i < N_ROWS; i++) popcnt = popcnt + CNT_WIDTH'(v[i]);
   endfunction

   // The returned tag is redundant: completion is tracked by counting result lanes.
   assign unused_tag = expu_tag_i;

   always_comb begin
      expu_strb_o = '0;
      for (int i = 0; i < N_ROWS; i++) expu_strb_o[i] = (CNT_WIDTH'(i) < rem_q);
   end

   assign beat_k     = (rem_q < ROWS) ? rem_q : ROWS;
   assign expu_tag_o = (rem_q <= ROWS);

   assign expu_valid_o = (state_q == ISSUE) & in_valid_i;
   assign in_ready_o   = (state_q == ISSUE) & expu_ready_i;
   assign issue_fire   = expu_valid_o & expu_ready_i;

   assign res_cnt          = popcnt(expu_strb_i);
   assign out_valid_o      = rst_ni & expu_valid_i;
   assign expu_out_ready_o = out_ready_i;
   assign out_strb_o       = expu_strb_i;
   assign out_last_o       = out_valid_o & (pend_q <= res_cnt);
   assign res_fire         = out_valid_o & out_ready_i;

   assign busy_o        = (state_q == ISSUE) | (state_q == DRAIN);
   assign expu_enable_o = busy_o;
   assign done_o        = (state_q == DONE) & ~clear_i;
   assign expu_clear_o  = rst_ni & (clear_i | ((state_q == IDLE) & start_i & (len_i != '0)));

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      pend_d  = pend_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  state_d = ISSUE;
                  rem_d   = len_i;
                  pend_d  = len_i;
               end else begin
                  state_d = DONE;
               end
            end
         end
         ISSUE: begin
            if (issue_fire) begin
               rem_d = rem_q - beat_k;
               // A zero-latency EXPU can return the final result in the same cycle as the last issue.
               if (expu_tag_o) state_d = (res_fire & out_last_o) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (res_fire & out_last_o) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if ((state_q != IDLE) & res_fire)
         pend_d = (pend_q > res_cnt) ? (pend_q - res_cnt) : '0;
      if (clear_i) begin
         state_d = IDLE;
         rem_d   = '0;
         pend_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rem_q   <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: tb/tb_expu_sched.sv
// Scoreboard bench for expu_sched: jobs are sliced into expected beats up front, a monitor pops them as the DUT fires,
// and a randomly stalling in-order EXPU model loops issued beats back as results.
module tb_expu_sched;
   localparam int NR = 4;
   localparam int CW = 16;

   typedef struct packed {
      logic [NR-1:0] strb;
      logic          flag;
   } beat_t;

   logic          clk_i = 1'b0;
   logic          rst_ni, clear_i, start_i;
   logic [CW-1:0] len_i;
   logic          in_valid_i, in_ready_o, expu_valid_o, expu_ready_i;
   logic [NR-1:0] expu_strb_o;
   logic          expu_tag_o, expu_enable_o, expu_clear_o;
   logic          expu_valid_i;
   logic [NR-1:0] expu_strb_i;
   logic          expu_tag_i, expu_out_ready_o, out_valid_o, out_ready_i;
   logic [NR-1:0] out_strb_o;
   logic          out_last_o, busy_o, done_o;

   beat_t exp_iss[$];
   beat_t exp_res[$];
   beat_t pipe[$];
   int    checks = 0;
   int    failures = 0;
   int    done_cnt = 0;
   bit    always_rdy = 1'b0;
   bit    hold_out_low = 1'b0;
   bit    done_due = 1'b0;

   always #5 clk_i = ~clk_i;

   expu_sched #(.N_ROWS(NR), .CNT_WIDTH(CW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i), .len_i(len_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .expu_valid_o(expu_valid_o), .expu_ready_i(expu_ready_i),
      .expu_strb_o(expu_strb_o), .expu_tag_o(expu_tag_o),
      .expu_enable_o(expu_enable_o), .expu_clear_o(expu_clear_o),
      .expu_valid_i(expu_valid_i), .expu_strb_i(expu_strb_i), .expu_tag_i(expu_tag_i),
      .expu_out_ready_o(expu_out_ready_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_strb_o(out_strb_o), .out_last_o(out_last_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=event required=none", name);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   // A job of len elements is ceil(len/NR) beats; every beat is full except possibly the tagged last one.
   task automatic start_job(input int len);
      int    nb;
      int    last_lanes;
      beat_t b;
      tick();
      start_i = 1'b1;
      len_i   = CW'(len);
      nb = (len + NR - 1) / NR;
      last_lanes = len - NR * (nb - 1);
      for (int i = 0; i < nb; i++) begin
         b.flag = (i == nb - 1);
         b.strb = '0;
         for (int l = 0; l < NR; l++) b.strb[l] = b.flag ? (l < last_lanes) : 1'b1;
         exp_iss.push_back(b);
         exp_res.push_back(b);
      end
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done();
      int n0 = done_cnt;
      int t = 0;
      while (done_cnt == n0 && t < 3000) begin
         tick();
         t++;
      end
      if (done_cnt == n0) fail("done_timeout");
      check("issue_left", exp_iss.size(), 0);
      check("result_left", exp_res.size(), 0);
   endtask

   task automatic wait_issued();
      int t = 0;
      while (exp_iss.size() != 0 && t < 1000) begin
         tick();
         t++;
      end
      if (exp_iss.size() != 0) fail("issue_timeout");
   endtask

   task automatic run_job(input int len);
      start_job(len);
      wait_done();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_in_ready"}, in_ready_o, 0);
      check({tag, "_expu_valid"}, expu_valid_o, 0);
      check({tag, "_expu_enable"}, expu_enable_o, 0);
      check({tag, "_out_valid"}, out_valid_o, 0);
      check({tag, "_out_last"}, out_last_o, 0);
      check({tag, "_expu_clear"}, expu_clear_o, 0);
   endtask

   // In-order EXPU model with random stalls; flushed by expu_clear_o or reset.
   initial begin
      logic  m_ifire, m_rfire, m_clr;
      beat_t m_b;
      in_valid_i = 1'b1; expu_ready_i = 1'b1; expu_valid_i = 1'b1;
      expu_strb_i = '1; expu_tag_i = 1'b1; out_ready_i = 1'b1;
      @(posedge rst_ni);
      expu_valid_i = 1'b0;
      expu_strb_i  = '0;
      forever begin
         @(negedge clk_i);
         m_ifire = expu_valid_o & expu_ready_i;
         m_rfire = out_valid_o & out_ready_i;
         m_clr   = expu_clear_o | ~rst_ni;
         m_b     = {expu_strb_o, expu_tag_o};
         @(posedge clk_i);
         #1;
         if (m_clr) pipe.delete();
         else begin
            if (m_rfire && pipe.size() > 0) void'(pipe.pop_front());
            if (m_ifire) pipe.push_back(m_b);
         end
         in_valid_i   = always_rdy || ($urandom_range(0, 9) < 8);
         expu_ready_i = always_rdy || ($urandom_range(0, 3) != 0);
         out_ready_i  = !hold_out_low && (always_rdy || ($urandom_range(0, 3) != 0));
         expu_valid_i = (pipe.size() > 0) && (always_rdy || ($urandom_range(0, 3) != 0));
         expu_strb_i  = (pipe.size() > 0) ? pipe[0].strb : '0;
         expu_tag_i   = (pipe.size() > 0) ? pipe[0].flag : 1'b0;
      end
   end

   // Monitor: pops expectations on every fire and tracks when done_o is owed.
   initial begin
      beat_t e;
      bit    due_next;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            exp_iss.delete();
            exp_res.delete();
            done_due = 1'b0;
            continue;
         end
         if (done_o || done_due) check("done_o", done_o, done_due);
         if (done_o) done_cnt++;
         due_next = 1'b0;
         if (exp_iss.size() > 0 && busy_o) begin
            check("issue_valid_pass", expu_valid_o, in_valid_i);
            check("issue_ready_pass", in_ready_o, expu_ready_i);
         end else begin
            check("idle_expu_valid", expu_valid_o, 0);
            check("idle_in_ready", in_ready_o, 0);
         end
         check("out_ready_pass", expu_out_ready_o, out_ready_i);
         if (expu_valid_o && expu_ready_i) begin
            if (exp_iss.size() == 0) fail("issue_unexpected");
            else begin
               e = exp_iss.pop_front();
               check("issue_strb", expu_strb_o, e.strb);
               check("issue_tag", expu_tag_o, e.flag);
            end
         end
         if (out_valid_o && out_ready_i) begin
            if (exp_res.size() == 0) fail("result_unexpected");
            else begin
               e = exp_res.pop_front();
               check("result_strb", out_strb_o, e.strb);
               check("result_last", out_last_o, e.flag);
               due_next = e.flag;
            end
         end
         if (start_i && !busy_o && !done_o && !clear_i) begin
            check("clear_on_start", expu_clear_o, len_i != '0);
            if (len_i == '0) due_next = 1'b1;
         end
         if (clear_i) begin
            check("clear_pass", expu_clear_o, 1);
            exp_iss.delete();
            exp_res.delete();
            due_next = 1'b0;
         end
         done_due = due_next;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0; clear_i = 1'b1; start_i = 1'b1; len_i = CW'(5);
      #12;
      check_all_zero("reset");
      clear_i = 1'b0; start_i = 1'b0; len_i = '0;
      tick();
      rst_ni = 1'b1;
      tick();
      check("post_reset_busy", busy_o, 0);

      always_rdy = 1'b1;
      run_job(10);
      always_rdy = 1'b0;

      run_job(0);

      for (int j = 0; j < 8; j++) run_job($urandom_range(1, 37));
      run_job(4);
      run_job(1);

      hold_out_low = 1'b1;
      always_rdy = 1'b1;
      start_job(10);
      wait_issued();
      repeat (5) begin
         tick();
         check("stall_busy", busy_o, 1);
         check("stall_done", done_o, 0);
      end
      hold_out_low = 1'b0;
      always_rdy = 1'b0;
      wait_done();

      start_job(40);
      repeat (3) tick();
      check("mid_issue_busy", busy_o, 1);
      start_i = 1'b1;
      len_i = CW'(7);
      tick();
      start_i = 1'b0;
      wait_done();

      hold_out_low = 1'b1;
      start_job(12);
      wait_issued();
      tick();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check("clear_busy", busy_o, 0);
      check("clear_done", done_o, 0);
      hold_out_low = 1'b0;
      repeat (4) tick();
      check("clear_idle_busy", busy_o, 0);
      run_job(9);

      start_job(200);
      repeat (4) tick();
      check("pre_reset_busy", busy_o, 1);
      rst_ni = 1'b0;
      #1;
      check_all_zero("midjob_reset");
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      check("release_busy", busy_o, 0);
      check("release_done", done_o, 0);
      run_job(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
